// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter slice.
// Optional feature macro: RR_ARB_LOCK_EN (see rr_arbiter.sv).
package rr_arb_pkg;

    // Supported requester count range
    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 16;

    // Ceiling log2, used to size requester index fields
    function automatic int idx_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Successor of index k in a ring of n entries
    function automatic int rr_next(input int k, input int n);
        if (k + 1 >= n) begin
            return 0;
        end
        return k + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin winner search: first requester at or after ptr_i,
// wrapping around the ring. Produces a one-hot grant and its index.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_oh_o,
    output logic [ID_W-1:0]  grant_idx_o,
    output logic             grant_any_o
);

    int              scan_idx;
    logic [ID_W-1:0] scan_sel;

    // Walk the ring starting at the pointer and latch the first active request
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        scan_idx    = 0;
        scan_sel    = '0;
        for (int off = 0; off < N_REQ; off++) begin
            scan_idx = int'(ptr_i) + off;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            scan_sel = scan_idx[ID_W-1:0];
            if (!grant_any_o && req_i[scan_sel]) begin
                grant_any_o           = 1'b1;
                grant_idx_o           = scan_sel;
                grant_oh_o[scan_sel]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with a one-deep registered output stage.
// Optional feature macro: RR_ARB_LOCK_EN -- when defined, a requester may hold
// the grant across several beats with in_lock; otherwise in_lock is ignored.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 8,
    localparam int ID_W   = idx_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    input  logic [N_REQ-1:0]        in_lock,
    output logic [N_REQ-1:0]        in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [ID_W-1:0]         out_id,
    input  logic                    out_ready
);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("rr_arbiter: N_REQ must be within 2..16");
    end

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ID_W-1:0]   out_id_q,    out_id_d;
    logic [ID_W-1:0]   ptr_q,       ptr_d;

    logic [N_REQ-1:0]  pick_req;
    logic [N_REQ-1:0]  grant_oh;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic              slot_free;
    logic              xfer;
    logic [DATA_W-1:0] win_data;

`ifdef RR_ARB_LOCK_EN
    logic             lock_active_q, lock_active_d;
    logic [N_REQ-1:0] ptr_mask;

    // While locked, only the requester at the pointer may compete
    always_comb begin
        ptr_mask        = '0;
        ptr_mask[ptr_q] = 1'b1;
        pick_req        = lock_active_q ? (in_valid & ptr_mask) : in_valid;
    end
`else
    logic unused_lock;
    assign unused_lock = ^in_lock;

    // Pure round-robin: every valid requester competes
    always_comb begin
        pick_req = in_valid;
    end
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i       (pick_req),
        .ptr_i       (ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    assign slot_free = !out_valid_q || out_ready;
    assign xfer      = resetn && slot_free && grant_any;
    assign in_ready  = xfer ? grant_oh : '0;

    // Select the winning payload with constant slices so no variable part-select is needed
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                win_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state of the output stage, rotation pointer and lock
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_LOCK_EN
        lock_active_d = lock_active_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data;
            out_id_d    = grant_idx;
`ifdef RR_ARB_LOCK_EN
            if (in_lock[grant_idx]) begin
                lock_active_d = 1'b1;
                ptr_d         = grant_idx;
            end else begin
                lock_active_d = 1'b0;
                ptr_d         = ID_W'(rr_next(int'(grant_idx), N_REQ));
            end
`else
            ptr_d = ID_W'(rr_next(int'(grant_idx), N_REQ));
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
`ifdef RR_ARB_LOCK_EN
            lock_active_q <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
`ifdef RR_ARB_LOCK_EN
            lock_active_q <= lock_active_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N_REQ=4, DATA_W=8) with a beat scoreboard
// and a small round-robin reference model. Honours RR_ARB_LOCK_EN if defined.
module tb_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_lock;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_ready;

    logic [W-1:0]   dataVal [N];

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] data;
    } beat_t;

    beat_t sb[$];
    int    obsIds[$];
    int    obsData[$];

    int checkCount = 0;
    int failCount  = 0;

    int mPtr;
    bit mOutValid;
    bit mLock;

    always #5 clk = ~clk;

    // Pack per-requester payloads onto the flat data bus
    always_comb begin
        in_data = '0;
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = dataVal[i];
        end
    end

    rr_arbiter #(
        .N_REQ  (N),
        .DATA_W (W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_lock   (in_lock),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference winner: scan from the pointer around the ring
    function automatic int modelWinner(input logic [N-1:0] v, input int p, input bit lk);
        if (lk) begin
            return v[p] ? p : -1;
        end
        for (int off = 0; off < N; off++) begin
            if (v[(p + off) % N]) begin
                return (p + off) % N;
            end
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, check at the falling edge, advance the model
    task automatic applyStimulus(input logic rstn, input logic [N-1:0] v, input logic [N-1:0] lk, input logic rdy);
        int         win;
        logic [N-1:0] readyExp;
        bit         accept;
        beat_t      b;
        resetn    = rstn;
        in_valid  = v;
        in_lock   = lk;
        out_ready = rdy;
        @(negedge clk);
        win      = modelWinner(in_valid, mPtr, mLock);
        readyExp = '0;
        if (resetn && (!mOutValid || out_ready) && win >= 0) begin
            readyExp = N'(1 << win);
        end
        checkOutput("in_ready", in_ready, readyExp);
        checkOutput("out_valid", out_valid, mOutValid);
        if (mOutValid) begin
            checkOutput("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                checkOutput("out_id", out_id, sb[0].id);
                checkOutput("out_data", out_data, sb[0].data);
            end
        end
        accept = mOutValid && out_ready;
        if (!resetn) begin
            mOutValid = 1'b0;
            mPtr      = 0;
            mLock     = 1'b0;
            sb.delete();
        end else begin
            if (accept) begin
                obsIds.push_back(int'(out_id));
                obsData.push_back(int'(out_data));
                if (sb.size() > 0) begin
                    void'(sb.pop_front());
                end
            end
            if (readyExp != '0) begin
                b.id   = 2'(win);
                b.data = dataVal[win];
                sb.push_back(b);
                mOutValid = 1'b1;
`ifdef RR_ARB_LOCK_EN
                if (in_lock[win]) begin
                    mLock = 1'b1;
                    mPtr  = win;
                end else begin
                    mLock = 1'b0;
                    mPtr  = (win + 1) % N;
                end
`else
                mPtr = (win + 1) % N;
`endif
            end else if (accept) begin
                mOutValid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Compare the accepted-beat id log against a fixed expected sequence
    task automatic checkIdSeq(input string name, input int expIds[8], input int n);
        checkOutput({name, "_count"}, obsIds.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < obsIds.size()) begin
                checkOutput($sformatf("%s_id%0d", name, i), obsIds[i], expIds[i]);
            end
        end
    endtask

    initial begin
        int rotIds[8];
        int rotData[8];
        int wrapIds[8];
        int lockIds[8];
        rotIds  = '{0, 1, 2, 3, 0, 0, 0, 0};
        rotData = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA0, 0, 0, 0};
        wrapIds = '{0, 1, 0, 0, 0, 0, 0, 0};
`ifdef RR_ARB_LOCK_EN
        lockIds = '{1, 1, 1, 2, 0, 0, 0, 0};
`else
        lockIds = '{1, 2, 3, 0, 0, 0, 0, 0};
`endif
        resetn    = 1'b0;
        in_valid  = '0;
        in_lock   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            dataVal[i] = W'(8'hA0 + i);
        end
        mPtr      = 0;
        mOutValid = 1'b0;
        mLock     = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset with all requesters active");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1);
            checkOutput("rst_out_id", out_id, 0);
            checkOutput("rst_out_valid", out_valid, 0);
        end

        $display("[TB] rotation after release");
        obsIds.delete();
        obsData.delete();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1);
        end
        checkIdSeq("rot", rotIds, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < obsData.size()) begin
                checkOutput($sformatf("rot_data%0d", i), obsData[i], rotData[i]);
            end
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);

        $display("[TB] sparse single pulse");
        dataVal[2] = 8'h5C;
        applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b1);
        checkOutput("sparse_valid", out_valid, 1);
        checkOutput("sparse_id", out_id, 2);
        checkOutput("sparse_data", out_data, 8'h5C);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        checkOutput("sparse_drop", out_valid, 0);
        dataVal[2] = 8'hA2;

        $display("[TB] wrap and skip from pointer 3");
        obsIds.delete();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 4'b0011, 4'b0000, 1'b1);
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        checkIdSeq("wrap", wrapIds, 3);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
            checkOutput("bp_data", out_data, 8'hA1);
            checkOutput("bp_ready", in_ready, 0);
        end
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1);
        checkOutput("bp_valid_kept", out_valid, 1);
        checkOutput("bp_next_id", out_id, 2);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);

        $display("[TB] lock sequence from requester 1");
        applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        obsIds.delete();
        applyStimulus(1'b1, 4'b1111, 4'b0010, 1'b1);
        applyStimulus(1'b1, 4'b1111, 4'b0010, 1'b1);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        checkIdSeq("lock", lockIds, 4);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);

        $display("[TB] reset with a pending beat");
        applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);
        checkOutput("midrst_valid", out_valid, 0);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1);
        checkOutput("midrst_id", out_id, 0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
